// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the imem read block.
package imem_pkg;

    typedef enum logic [1:0] {HDR, DATA, CSUM, DONE} ld_state_t;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1024;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream; word/word_valid
// present the completed word combinationally in the cycle its 4th byte is consumed.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;

    // Bytes enter at the top and shift down, so byte 0 ends up in bits [7:0].
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (clear) begin
            byte_cnt_d = 2'd0;
        end else if (byte_valid) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {byte_in, shift_q[31:8]};
        end
    end

    assign word       = {byte_in, shift_q[31:8]};
    assign word_valid = byte_valid && !clear && (byte_cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads the program image from the UART byte stream into imem and holds the core
// in reset until complete. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

    ld_state_t         state_q, state_d;
    logic [31:0]       word_cnt_q, word_cnt_d;
    logic [31:0]       len_q, len_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              core_hold_q, core_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        consume;
    logic        packer_clear;
    logic [31:0] word;
    logic        word_valid;
    logic        in_range;

    assign rx_ready = (state_q != DONE);
    assign consume  = rx_valid && rx_ready;
    assign in_range = ({1'b0, word_cnt_q} < DEPTH);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packer_clear),
        .byte_in    (rx_data),
        .byte_valid (consume),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        len_d        = len_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        done_d       = done_q;
        err_d        = err_q;
        core_hold_d  = core_hold_q;
        packer_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            HDR: begin
                if (word_valid) begin
                    len_d      = word;
                    word_cnt_d = 32'd0;
                    if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d     = CSUM;
`else
                        state_d     = DONE;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (consume) begin
                    csum_d = csum_q ^ rx_data;
                end
`endif
                if (word_valid) begin
                    // Words beyond the memory are consumed but dropped; waddr holds.
                    if (in_range) begin
                        we_d    = 1'b1;
                        waddr_d = word_cnt_q[ADDR_W-1:0];
                        wdata_d = word;
                    end else begin
                        err_d = 1'b1;
                    end
                    word_cnt_d = word_cnt_q + 32'd1;
                    if (word_cnt_q == len_q - 32'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d     = CSUM;
`else
                        state_d     = DONE;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (consume) begin
                    if (rx_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d     = DONE;
                    done_d      = 1'b1;
                    core_hold_d = 1'b0;
                end
            end
`endif
            DONE: begin
                if (reload) begin
                    state_d      = HDR;
                    word_cnt_d   = 32'd0;
                    len_d        = 32'd0;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    core_hold_d  = 1'b1;
                    packer_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d       = 8'd0;
`endif
                end
            end
            default: begin
                state_d = HDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HDR;
            word_cnt_q  <= 32'd0;
            len_q       <= 32'd0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            core_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            core_hold_q <= core_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign core_hold = core_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes come from an
// image-level model (word list, depth limit, XOR of payload bytes).
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              reload;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              core_hold;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .reload    (reload),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0]       imgWords[$];
    logic [ADDR_W-1:0] capAddr[$];
    logic [31:0]       capData[$];
    logic              lastDone = 1'b0;
    logic              lastHold = 1'b1;
    logic              prevWe   = 1'b0;
    int                weDouble = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Capture every write pulse along with done/core_hold seen in that same cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (we === 1'b1) begin
                capAddr.push_back(waddr);
                capData.push_back(wdata);
                lastDone <= done;
                lastHold <= core_hold;
                if (prevWe === 1'b1) weDouble <= weDouble + 1;
            end
            prevWe <= we;
        end else begin
            prevWe <= 1'b0;
        end
    end

    // Offer one byte after a random idle gap; starts and ends just after a negedge.
    task automatic applyStimulus(input logic [7:0] b, input int maxGap);
        int gap;
        gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic loadImage(input int n, input int maxGap, input logic [7:0] csumDelta,
                             input bit checkTiming, input string tag);
        logic [7:0]  csum;
        logic [31:0] w;
        logic [31:0] nWord;
        logic        expErr;
        int          expWrites;
        capAddr.delete();
        capData.delete();
        csum  = 8'h00;
        nWord = 32'(n);
        for (int k = 0; k < 4; k++) applyStimulus(nWord[8*k +: 8], maxGap);
        for (int i = 0; i < n; i++) begin
            w = imgWords[i];
            for (int k = 0; k < 4; k++) begin
                csum = csum ^ w[8*k +: 8];
                applyStimulus(w[8*k +: 8], maxGap);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(csum ^ csumDelta, maxGap);
        expErr = (n > DEPTH) || (csumDelta != 8'h00);
`else
        expErr = (n > DEPTH);
`endif
        checkOutput({tag, ".doneNow"}, 32'(done), 32'd1);
        #1;
        expWrites = (n > DEPTH) ? DEPTH : n;
        checkOutput({tag, ".numWrites"}, 32'(capAddr.size()), 32'(expWrites));
        for (int i = 0; i < expWrites && i < capAddr.size(); i++) begin
            checkOutput($sformatf("%s.waddr[%0d]", tag, i), 32'(capAddr[i]), 32'(i));
            checkOutput($sformatf("%s.wdata[%0d]", tag, i), capData[i], imgWords[i]);
        end
        checkOutput({tag, ".err"}, 32'(err), 32'(expErr));
        checkOutput({tag, ".coreHold"}, 32'(core_hold), 32'd0);
        checkOutput({tag, ".rxReady"}, 32'(rx_ready), 32'd0);
        if (checkTiming && n > 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            checkOutput({tag, ".doneAtLastWe"}, 32'(lastDone), 32'd0);
            checkOutput({tag, ".holdAtLastWe"}, 32'(lastHold), 32'd1);
`else
            checkOutput({tag, ".doneAtLastWe"}, 32'(lastDone), 32'd1);
            checkOutput({tag, ".holdAtLastWe"}, 32'(lastHold), 32'd0);
`endif
        end
    endtask

    task automatic doReload(input string tag);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        #1;
        checkOutput({tag, ".coreHold"}, 32'(core_hold), 32'd1);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".err"}, 32'(err), 32'd0);
        checkOutput({tag, ".rxReady"}, 32'(rx_ready), 32'd1);
    endtask

    task automatic randomImage(input int n);
        imgWords.delete();
        for (int i = 0; i < n; i++) imgWords.push_back($urandom);
    endtask

    initial begin
        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset.we", 32'(we), 32'd0);
        checkOutput("reset.waddr", 32'(waddr), 32'd0);
        checkOutput("reset.wdata", wdata, 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.err", 32'(err), 32'd0);
        checkOutput("reset.coreHold", 32'(core_hold), 32'd1);
        checkOutput("reset.rxReady", 32'(rx_ready), 32'd1);
        #1 rst = 1'b1;
        @(negedge clk);

        imgWords = '{32'h00000013, 32'h00100093};
        loadImage(2, 0, 8'h00, 1'b1, "twoWords");
        doReload("reload1");

        imgWords.delete();
        loadImage(0, 0, 8'h00, 1'b0, "zeroLen");
        capAddr.delete();
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        #1;
        checkOutput("doneIdle.writes", 32'(capAddr.size()), 32'd0);
        checkOutput("doneIdle.done", 32'(done), 32'd1);
        doReload("reload2");

        randomImage(DEPTH + 1);
        loadImage(DEPTH + 1, 1, 8'h00, 1'b0, "overflow");
        doReload("reload3");

        randomImage(5);
        loadImage(5, 3, 8'h00, 1'b1, "gappy");
        doReload("reload4");

        // Abandon a load part-way through word 1 with an asynchronous reset.
        randomImage(3);
        for (int k = 0; k < 4; k++) applyStimulus(8'(k == 0 ? 3 : 0), 0);
        for (int k = 0; k < 4; k++) applyStimulus(imgWords[0][8*k +: 8], 0);
        applyStimulus(imgWords[1][7:0], 0);
        applyStimulus(imgWords[1][15:8], 0);
        #1 rst = 1'b0;
        #1;
        checkOutput("midReset.we", 32'(we), 32'd0);
        checkOutput("midReset.waddr", 32'(waddr), 32'd0);
        checkOutput("midReset.wdata", wdata, 32'd0);
        checkOutput("midReset.coreHold", 32'(core_hold), 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        imgWords = '{32'hDEADBEEF};
        loadImage(1, 2, 8'h00, 1'b1, "afterReset");
        doReload("reload5");

        randomImage(int'($urandom_range(6, 2)));
        loadImage(imgWords.size(), 2, 8'h00, 1'b1, "reloaded");

`ifdef IMEM_LOADER_CHECKSUM_EN
        doReload("reload6");
        imgWords = '{32'h44332211};
        loadImage(1, 0, 8'h00, 1'b1, "csumGood");
        doReload("reload7");
        loadImage(1, 0, 8'h01, 1'b1, "csumBad");
`endif

        checkOutput("weBackToBack", 32'(weDouble), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
